// File: rtl/chain_drain_scheduler_pkg.sv
// Shared state encoding and small elaboration-time helpers for the
// capture-and-drain scheduler.
package chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    COMPLETE,
    ABORT
  } state_t;

  // Bits needed to hold values 0..n-1; 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Low bit of lane k's chain index inside the flat lane_sel bus.
  function automatic int sel_lo(input int lane, input int sel_w);
    return lane * sel_w;
  endfunction

endpackage

// File: rtl/chain_drain_scheduler_rr_picker.sv
// Round-robin first-set search: lowest set bit of mask at or after start,
// wrapping modulo N.
module rr_picker
  import chain_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] rot;
  logic [W:0]     sum;

  // Rotating a doubled copy puts the search origin at bit 0 so the
  // scan below only uses constant bit positions.
  always_comb begin
    rot   = {mask, mask} >> start;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int o = 0; o < N; o++) begin
      if (!found && rot[o]) begin
        found = 1'b1;
        sum   = {1'b0, start} + (W+1)'(o);
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        idx   = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/chain_drain_scheduler.sv
// Sequences one capture-and-drain pass over CHAINS_IN shadow chains that
// share CHAINS_OUT serial lanes, granting lanes round-robin.
module chain_drain_scheduler
  import chain_pkg::*;
#(
  parameter int CHAINS_IN  = 5,
  parameter int CHAINS_OUT = 3,
  parameter int CAP_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  parameter int SEL_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trig,
  input  logic [CHAINS_IN-1:0]        cin_ready,
  input  logic [CHAINS_IN-1:0]        cin_done,
  output logic                        c_en,
  output logic [CHAINS_IN-1:0]        cin_en,
  output logic [CHAINS_OUT-1:0]       lane_valid,
  output logic [CHAINS_OUT*SEL_W-1:0] lane_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int CAP_W = clog2(CAP_CYCLES + 1);
  localparam int TMR_W = clog2(TIMEOUT + 1);

  state_t                      state, state_n;
  logic [CAP_W-1:0]            cap_cnt, cap_n;
  logic [TMR_W-1:0]            tmr, tmr_n;
  logic [CHAINS_IN-1:0]        pending, pend_n;
  logic [SEL_W-1:0]            ptr, ptr_n;
  logic [CHAINS_OUT-1:0]       lv_n;
  logic [CHAINS_OUT*SEL_W-1:0] ls_n;
  logic                        err_n;

  logic [CHAINS_OUT-1:0]       rel, free_oh;
  logic [CHAINS_IN-1:0]        rel_chain, cand;
  logic                        pick_found;
  logic [SEL_W-1:0]            pick_idx;
  logic                        grant, progress;

  // Decode lane ownership into per-chain enables and find lanes whose
  // owner reports done; done on an unowned chain never matches here.
  always_comb begin
    cin_en    = '0;
    rel       = '0;
    rel_chain = '0;
    for (int k = 0; k < CHAINS_OUT; k++)
      for (int i = 0; i < CHAINS_IN; i++)
        if (lane_valid[k] && lane_sel[sel_lo(k, SEL_W) +: SEL_W] == SEL_W'(i)) begin
          cin_en[i] = 1'b1;
          if (cin_done[i]) begin
            rel[k]       = 1'b1;
            rel_chain[i] = 1'b1;
          end
        end
  end

  // Lowest free lane as one-hot (x & -x on the free mask); lanes released
  // this cycle still count as busy.
  assign free_oh = ~lane_valid & (lane_valid + CHAINS_OUT'(1));

  assign cand = pending & cin_ready & ~cin_en;

  rr_picker #(
    .N (CHAINS_IN),
    .W (SEL_W)
  ) u_pick (
    .mask  (cand),
    .start (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant    = (state == DRAIN) && (|free_oh) && pick_found;
  assign progress = grant || (|rel);

  assign c_en = (state == CAPTURE);
  assign busy = (state != IDLE);
  assign done = (state == COMPLETE) || (state == ABORT);

  always_comb begin
    state_n = state;
    cap_n   = cap_cnt;
    tmr_n   = tmr;
    pend_n  = pending;
    ptr_n   = ptr;
    lv_n    = lane_valid;
    ls_n    = lane_sel;
    err_n   = err;
    case (state)
      IDLE: begin
        if (trig) begin
          state_n = CAPTURE;
          err_n   = 1'b0;
          pend_n  = '1;
          cap_n   = '0;
          tmr_n   = '0;
        end
      end
      CAPTURE: begin
        if (cap_cnt == CAP_W'(CAP_CYCLES - 1)) state_n = DRAIN;
        else                                   cap_n   = cap_cnt + CAP_W'(1);
      end
      DRAIN: begin
        lv_n   = lane_valid & ~rel;
        pend_n = pending & ~rel_chain;
        if (grant) begin
          lv_n  = lv_n | free_oh;
          ptr_n = (pick_idx == SEL_W'(CHAINS_IN - 1)) ? '0 : pick_idx + SEL_W'(1);
          for (int k = 0; k < CHAINS_OUT; k++)
            if (free_oh[k]) ls_n[sel_lo(k, SEL_W) +: SEL_W] = pick_idx;
        end
        if (pending == '0 && lane_valid == '0) begin
          state_n = COMPLETE;
        end else if (progress) begin
          tmr_n = '0;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          // Abort drops every lane now so the ABORT cycle already shows them idle.
          state_n = ABORT;
          lv_n    = '0;
          pend_n  = '0;
          err_n   = 1'b1;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      COMPLETE: state_n = IDLE;
      ABORT:    state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_cnt    <= '0;
      tmr        <= '0;
      pending    <= '0;
      ptr        <= '0;
      lane_valid <= '0;
      lane_sel   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cap_cnt    <= cap_n;
      tmr        <= tmr_n;
      pending    <= pend_n;
      ptr        <= ptr_n;
      lane_valid <= lv_n;
      lane_sel   <= ls_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_chain_drain_scheduler.sv
// Scoreboard bench for chain_drain_scheduler: expected lane grants are queued
// per scenario and matched against grants seen on lane_valid rising edges.
module tb_chain_drain_scheduler;
  localparam int CI = 5, CO = 3, CAP = 2, TO = 10, SW = 3;
  localparam int NEVER = 1000;

  logic clk = 1'b0, rst = 1'b1, trig = 1'b0;
  logic [CI-1:0] cin_ready = '0, cin_done = '0;
  logic c_en, busy, done, err;
  logic [CI-1:0] cin_en;
  logic [CO-1:0] lane_valid;
  logic [CO*SW-1:0] lane_sel;

  chain_drain_scheduler #(
    .CHAINS_IN(CI), .CHAINS_OUT(CO), .CAP_CYCLES(CAP), .TIMEOUT(TO), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .cin_ready(cin_ready), .cin_done(cin_done),
    .c_en(c_en), .cin_en(cin_en), .lane_valid(lane_valid), .lane_sel(lane_sel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] lane; logic [3:0] chain; logic [15:0] cyc; } gr_t;
  gr_t exp_q[$], obs_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, cen_cnt = 0, done_cnt = 0, done_cyc = -1;
  int dly[CI], ready_at[CI], ready_end[CI], gcyc[CI];
  int spur_lo = 0, spur_hi = -1;
  logic [CI-1:0] prev_en = '0, spur_mask = '0;
  logic [CO-1:0] prev_valid = '0;

  // Chain model: ready inside [ready_at, ready_end), done dly cycles after grant.
  task automatic drive_chains();
    for (int i = 0; i < CI; i++) begin
      cin_ready[i] = (cyc >= ready_at[i]) && (cyc < ready_end[i]);
      cin_done[i]  = cin_en[i] && (dly[i] != 0) && (cyc - gcyc[i] == dly[i]);
      if (spur_mask[i] && cyc >= spur_lo && cyc <= spur_hi) cin_done[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < CO; k++)
      if (lane_valid[k] && !prev_valid[k])
        obs_q.push_back(gr_t'{lane: 4'(k), chain: 4'(lane_sel[k*SW +: SW]), cyc: 16'(cyc)});
    prev_valid = lane_valid;
    for (int i = 0; i < CI; i++)
      if (cin_en[i] && !prev_en[i]) gcyc[i] = cyc;
    prev_en = cin_en;
    if (c_en) cen_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    drive_chains();
  endtask

  task automatic set_all(input int d, input int rat);
    for (int i = 0; i < CI; i++) begin
      dly[i] = d; ready_at[i] = rat; ready_end[i] = NEVER; gcyc[i] = 0;
    end
    spur_mask = '0; spur_lo = 0; spur_hi = -1;
  endtask

  // Trigger sampled in cycle 0; returns in cycle 1.
  task automatic launch(input bit hold);
    cyc = 0; cen_cnt = 0; done_cnt = 0; done_cyc = -1;
    trig = 1'b1;
    drive_chains();
    tick();
    if (!hold) trig = 1'b0;
  endtask

  task automatic push(input int lane, input int chain, input int c);
    exp_q.push_back(gr_t'{lane: 4'(lane), chain: 4'(chain), cyc: 16'(c)});
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_cmp++;
    if ({c_en, cin_en, lane_valid, lane_sel, busy, done, err} !== 21'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, expected 0", {c_en, cin_en, lane_valid, lane_sel, busy, done, err});
    end
    rst = 1'b0; tick();
    n_cmp++;
    if ({c_en, cin_en, lane_valid, busy, done, err} !== 12'd0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h, expected 0", {c_en, cin_en, lane_valid, busy, done, err});
    end
  endtask

  task automatic test_basic();
    gr_t e, o;
    set_all(8, 0);
    push(0, 0, 4); push(1, 1, 5); push(2, 2, 6); push(0, 3, 14); push(1, 4, 15);
    launch(1'b0);
    n_cmp++; if (c_en !== 1'b1) begin n_bad++; $display("FAIL basic_cen_c1: got %b, expected 1", c_en); end
    tick();
    n_cmp++; if (c_en !== 1'b1) begin n_bad++; $display("FAIL basic_cen_c2: got %b, expected 1", c_en); end
    tick();
    n_cmp++; if ({c_en, busy} !== 2'b01) begin n_bad++; $display("FAIL basic_drain_c3: c_en/busy %b, expected 01", {c_en, busy}); end
    while (cyc < 27) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL basic_grant: missing, expected lane %0d chain %0d cyc %0d", e.lane, e.chain, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL basic_grant: got lane %0d chain %0d cyc %0d, expected lane %0d chain %0d cyc %0d", o.lane, o.chain, o.cyc, e.lane, e.chain, e.cyc); end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL basic_extra: %0d extra grants, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (cen_cnt != 2) begin n_bad++; $display("FAIL basic_cen_width: got %0d, expected 2", cen_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 25) begin n_bad++; $display("FAIL basic_done: count %0d cyc %0d, expected 1 at 25", done_cnt, done_cyc); end
    n_cmp++; if ({err, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_end: err/busy %b, expected 00", {err, busy}); end
  endtask

  task automatic test_trig_held();
    gr_t e, o;
    set_all(4, 0);
    push(0, 0, 4); push(1, 1, 5); push(2, 2, 6); push(0, 3, 10); push(1, 4, 11);
    launch(1'b1);
    while (cyc < 21) begin
      tick();
      if (cyc >= 18) trig = 1'b0;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL held_grant: missing, expected lane %0d chain %0d cyc %0d", e.lane, e.chain, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL held_grant: got lane %0d chain %0d cyc %0d, expected lane %0d chain %0d cyc %0d", o.lane, o.chain, o.cyc, e.lane, e.chain, e.cyc); end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL held_extra: %0d extra grants, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (cen_cnt != 2) begin n_bad++; $display("FAIL held_cen: got %0d cycles, expected 2", cen_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 17) begin n_bad++; $display("FAIL held_done: count %0d cyc %0d, expected 1 at 17", done_cnt, done_cyc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL held_idle: busy %b, expected 0", busy); end
  endtask

  // Lane1 frees first while chain 4 waits; chain 3 sees stray done while unowned;
  // chain 4 drops ready while it owns a lane.
  task automatic test_simul_release();
    gr_t e, o;
    set_all(8, 0);
    dly[1] = 3; ready_at[3] = 13; ready_end[4] = 12;
    spur_mask = 5'b01000; spur_lo = 8; spur_hi = 12;
    push(0, 0, 4); push(1, 1, 5); push(2, 2, 6); push(1, 4, 10); push(0, 3, 14);
    launch(1'b0);
    while (cyc < 9) tick();
    n_cmp++; if (lane_valid[1] !== 1'b0) begin n_bad++; $display("FAIL simul_lane1_free: got %b, expected 0", lane_valid[1]); end
    while (cyc < 26) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL simul_grant: missing, expected lane %0d chain %0d cyc %0d", e.lane, e.chain, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL simul_grant: got lane %0d chain %0d cyc %0d, expected lane %0d chain %0d cyc %0d", o.lane, o.chain, o.cyc, e.lane, e.chain, e.cyc); end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL simul_extra: %0d extra grants, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 24 || err !== 1'b0) begin n_bad++; $display("FAIL simul_done: count %0d cyc %0d err %b, expected 1 at 24 err 0", done_cnt, done_cyc, err); end
  endtask

  task automatic test_timeout();
    gr_t e, o;
    set_all(8, 0);
    ready_at[2] = NEVER;
    push(0, 4, 4); push(1, 0, 5); push(2, 1, 6); push(0, 3, 14);
    launch(1'b0);
    while (cyc < 33) tick();
    n_cmp++;
    if ({done, err, lane_valid, cin_en} !== {2'b11, 3'b000, 5'b00000}) begin
      n_bad++; $display("FAIL timeout_abort: done %b err %b lanes %b cin_en %b, expected 1 1 000 00000", done, err, lane_valid, cin_en);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL timeout_grant: missing, expected lane %0d chain %0d cyc %0d", e.lane, e.chain, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL timeout_grant: got lane %0d chain %0d cyc %0d, expected lane %0d chain %0d cyc %0d", o.lane, o.chain, o.cyc, e.lane, e.chain, e.cyc); end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL timeout_extra: %0d extra grants, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (done_cnt != 1 || err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_end: done count %0d err %b busy %b, expected 1 1 0", done_cnt, err, busy); end
  endtask

  // First pass leaves the pointer at 3 (and clears the sticky err); second
  // pass with only chains 1 and 3 ready must start from chain 3.
  task automatic test_rr_persist();
    gr_t e, o;
    set_all(8, NEVER);
    ready_at[0] = 0; ready_at[1] = 0; ready_at[2] = 0;
    push(0, 0, 4); push(1, 1, 5); push(2, 2, 6);
    launch(1'b0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err_clear: got %b, expected 0", err); end
    while (cyc < 26) tick();
    n_cmp++; if (done_cyc != 25 || err !== 1'b1) begin n_bad++; $display("FAIL rr_setup_abort: done cyc %0d err %b, expected 25 1", done_cyc, err); end
    set_all(8, NEVER);
    ready_at[1] = 0; ready_at[3] = 0;
    push(0, 3, 4); push(1, 1, 5);
    launch(1'b0);
    while (cyc < 25) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL rr_grant: missing, expected lane %0d chain %0d cyc %0d", e.lane, e.chain, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL rr_grant: got lane %0d chain %0d cyc %0d, expected lane %0d chain %0d cyc %0d", o.lane, o.chain, o.cyc, e.lane, e.chain, e.cyc); end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rr_extra: %0d extra grants, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (done_cyc != 24) begin n_bad++; $display("FAIL rr_abort: done cyc %0d, expected 24", done_cyc); end
  endtask

  task automatic test_reset_mid();
    gr_t e, o;
    set_all(8, 0);
    push(0, 2, 4); push(1, 3, 5);
    launch(1'b0);
    while (cyc < 5) tick();
    #1 rst = 1'b1; #1;
    n_cmp++;
    if ({c_en, cin_en, lane_valid, lane_sel, busy, done, err} !== 21'd0) begin
      n_bad++; $display("FAIL rstmid_async: got %h, expected 0", {c_en, cin_en, lane_valid, lane_sel, busy, done, err});
    end
    tick(); tick(); rst = 1'b0; tick();
    set_all(8, 0);
    push(0, 0, 4); push(1, 1, 5); push(2, 2, 6); push(0, 3, 14); push(1, 4, 15);
    launch(1'b0);
    while (cyc < 27) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL rstmid_grant: missing, expected lane %0d chain %0d cyc %0d", e.lane, e.chain, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL rstmid_grant: got lane %0d chain %0d cyc %0d, expected lane %0d chain %0d cyc %0d", o.lane, o.chain, o.cyc, e.lane, e.chain, e.cyc); end
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rstmid_extra: %0d extra grants, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 25 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: count %0d cyc %0d err %b, expected 1 at 25 err 0", done_cnt, done_cyc, err); end
  endtask

  initial begin
    set_all(0, NEVER);
    test_reset();
    test_basic();
    test_trig_held();
    test_simul_release();
    test_timeout();
    test_rr_persist();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chain_drain_scheduler.md
Name: chain_drain_scheduler

Overview:
- Sequences one capture-and-drain cycle across CHAINS_IN shadow chains that share CHAINS_OUT serial output lanes.
- On a trigger it pulses the chain capture enable, then grants ready chains to free lanes in round-robin order.
- It releases each lane when the chain reports done, and signals completion or timeout.
- Sits between the shadow_chain instances and the lane mux / interpreter; it drives cin_en and a per-lane chain index.

Parameters:
- CHAINS_IN, 5, number of shadow chains.
- CHAINS_OUT, 3, number of output lanes.
- CAP_CYCLES, 2, width of the c_en capture pulse in clk cycles (>=1).
- TIMEOUT, 255, number of no-progress cycles before abort (>=1).
- SEL_W, 3, chain index width, >= clog2(CHAINS_IN).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- trig  in  1  start request; sampled only in IDLE.
- cin_ready  in  CHAINS_IN  per-chain captured-and-ready flag.
- cin_done  in  CHAINS_IN  per-chain shift-out complete flag.
- c_en  out  1  capture enable to all chains.
- cin_en  out  CHAINS_IN  shift enable; bit i high while chain i owns a lane.
- lane_valid  out  CHAINS_OUT  lane k currently assigned.
- lane_sel  out  CHAINS_OUT*SEL_W  chain index per lane; lane k occupies bits [k*SEL_W +: SEL_W].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of every sequence.
- err  out  1  sticky timeout flag; cleared by the next accepted trig.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending mask 0, rr pointer 0, timers 0.
- State IDLE:
  - trig=1 → CAPTURE, clear err, pending = all ones.
  - trig is ignored in every other state.
- State CAPTURE:
  - c_en=1 for exactly CAP_CYCLES cycles, starting the cycle after trig is sampled.
  - Then → DRAIN.
- State DRAIN, evaluated each cycle:
  - Release: for every valid lane k with cin_done[lane_sel_k]=1, next cycle lane_valid[k]=0, cin_en of that chain=0, and the chain's pending bit is cleared. Multiple releases in one cycle are allowed.
  - Grant: at most one grant per cycle. The target is the lowest-index lane free at the start of the cycle; a lane freed in the same cycle is not reusable until the next cycle.
  - Candidate chains are pending, cin_ready=1 and not already assigned. Pick the first candidate at or after the rr pointer, wrapping modulo CHAINS_IN.
  - A grant takes effect the next cycle: lane_valid=1, lane_sel=index, cin_en[index]=1. The rr pointer moves to index+1, wrapping to 0 after CHAINS_IN-1.
  - No candidate or no free lane → no grant, pointer unchanged.
  - Completion: pending==0 and no lane valid → COMPLETE.
  - Progress timer: cleared on any grant or release, otherwise increments. When it reaches TIMEOUT → ABORT.
- State COMPLETE: done=1 for one cycle → IDLE.
- State ABORT, one cycle:
  - All lane_valid and cin_en forced to 0, pending cleared.
  - err=1 (sticky), done=1.
  - → IDLE.
- Boundary rules:
  - CHAINS_OUT >= CHAINS_IN: every chain can be granted, one per cycle.
  - A chain that is never ready triggers a timeout, even if other chains drained.
  - cin_done on an unassigned chain is ignored.
  - cin_ready deasserting on an assigned chain is ignored; the lane is held until done.
  - Async rst mid-sequence returns immediately to reset values; partial grants are discarded.
- Latency: trig to first possible grant visible = 1 + CAP_CYCLES + 1 cycles.

Decomposition:
- Package chain_pkg holds:
  - the state enum IDLE/CAPTURE/DRAIN/COMPLETE/ABORT;
  - a clog2 function for SEL_W;
  - the lane_sel slice helper.
- One sub-module, rr_picker: combinational round-robin first-set search over a CHAINS_IN mask from a start pointer, returning found and index.

Test Plan:
- Basic drain, defaults: trig at cycle 0, all ready by cycle 4, each chain's done asserted 8 cycles after its grant.
  - c_en high in cycles 1-2.
  - Grants in order chain0→lane0, chain1→lane1, chain2→lane2.
  - Chains 3 and 4 are granted only after lanes free, to the lowest free lane.
  - A single done pulse follows; err=0.
- Round-robin ordering: only chains 3 and 1 ready.
  - Chain 3 is granted first (pointer=3 from the prior sequence) only if the pointer persists; otherwise 1 then 3.
  - Check that the pointer persists across sequences.
- Simultaneous release and grant: lanes full, lane1 done while chain 4 waits.
  - Chain 4 is granted to lane1 two cycles after the done cycle, not one.
- Timeout with TIMEOUT=10: chain 2 never ready.
  - The other four drain, then after 10 idle cycles the sequence aborts.
  - err=1, done pulse, all cin_en=0; the next trig clears err.
- Reset mid-drain: assert rst with 2 lanes valid.
  - All outputs 0 asynchronously; a new trig after rst release restarts cleanly with the pointer at 0.
- trig held high during DRAIN: no restart and no extra c_en pulse.
